// File: rtl/if_fetch_pkg.sv
// if_fetch_pkg: shared core constants and the fetch buffer entry type.
package if_fetch_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] RESET_PC_DEF = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR_DEF = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] instr;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] a);
        return {a[XLEN-1:2], 2'b00};
    endfunction
endpackage

// File: rtl/if_fetch_if.sv
// if_fetch_if: IRAM read port and decode handshake of the fetch stage.
interface if_fetch_if;
    import if_fetch_pkg::*;
    logic mem_rd;
    logic mem_wr;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] rdata;
    logic if_valid;
    logic id_ready;
    logic [XLEN-1:0] if_pc;
    logic [XLEN-1:0] if_instr;

    modport master(output mem_rd, mem_wr, addr, if_valid, if_pc, if_instr, input rdata, id_ready);
    modport slave(input mem_rd, mem_wr, addr, if_valid, if_pc, if_instr, output rdata, id_ready);
endinterface

// File: rtl/if_fetch_buf.sv
// if_fetch_buf: 2-entry {pc, instr} FIFO; flush beats push, an empty head reads as {0, NOP}.
module if_fetch_buf
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic         sclk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic         flush,
    input  fetch_entry_t din,
    output logic [1:0]   count,
    output fetch_entry_t head
);
    localparam fetch_entry_t EMPTY = '{pc: '0, instr: NOP_INSTR};

    fetch_entry_t mem [2];
    logic wr_ptr;
    logic rd_ptr;

    always_ff @(posedge sclk) begin
        if (rst) begin
            mem <= '{EMPTY, EMPTY};
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count <= 2'd0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= din;
                wr_ptr <= !wr_ptr;
            end
            if (pop) rd_ptr <= !rd_ptr;
            count <= count + {1'b0, push} - {1'b0, pop};
        end
    end

    assign head = (count == 2'd0) ? EMPTY : mem[rd_ptr];
endmodule

// File: rtl/if_fetch.sv
// if_fetch: sequential PC generation and IRAM read issue, with a 2-deep buffer
// absorbing the 1-cycle read latency in front of decode.
module if_fetch
    import if_fetch_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC  = RESET_PC_DEF,
    parameter logic [XLEN-1:0] NOP_INSTR = NOP_INSTR_DEF
) (
    input  logic            sclk,
    input  logic            rst,
    input  logic            fetch_en,
    input  logic            redirect_vld,
    input  logic [XLEN-1:0] redirect_pc,
    if_fetch_if.master      bus
);
    logic [XLEN-1:0] pc_req;
    logic [XLEN-1:0] inflight_pc;
    logic inflight;
    logic stale;
    logic issue;
    logic pop;
    logic push;
    logic [1:0] count;
    logic [2:0] occupancy;
    fetch_entry_t head;
    fetch_entry_t din;

    // The read issued last cycle returns during the redirect cycle itself, so that is the one dropped.
    assign stale = redirect_vld;
    assign pop = bus.if_valid & bus.id_ready;
    assign push = inflight & !stale;
    assign occupancy = {1'b0, count} + {2'b0, push} - {2'b0, pop};
    assign issue = !rst & fetch_en & (redirect_vld | (occupancy < 3'd2));

    assign bus.mem_rd = issue;
    assign bus.mem_wr = 1'b0;
    assign bus.addr = rst ? RESET_PC : redirect_vld ? word_align(redirect_pc) : pc_req;
    assign bus.if_valid = !rst & (count != 2'd0);
    assign bus.if_pc = rst ? '0 : head.pc;
    assign bus.if_instr = rst ? NOP_INSTR : head.instr;
    assign din = '{pc: inflight_pc, instr: bus.rdata};

    always_ff @(posedge sclk) begin
        if (rst) begin
            pc_req <= RESET_PC;
            inflight <= 1'b0;
            inflight_pc <= '0;
        end else begin
            pc_req <= bus.addr + (issue ? 32'd4 : 32'd0);
            inflight <= issue;
            if (issue) inflight_pc <= bus.addr;
        end
    end

    if_fetch_buf #(.NOP_INSTR(NOP_INSTR)) u_buf (
        .sclk(sclk),
        .rst(rst),
        .push(push),
        .pop(pop),
        .flush(redirect_vld),
        .din(din),
        .count(count),
        .head(head)
    );
endmodule

// File: tb/tb_if_fetch.sv
// tb_if_fetch: directed and randomized bench; a monitor checks every accepted
// instruction against the expected PC stream (restarted at reset and at each redirect).
`timescale 1ns/1ps
module tb_if_fetch;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic sclk = 1'b0;
    logic rst = 1'b1;
    logic fetch_en = 1'b0;
    logic redirect_vld = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    int n_vec = 0;
    int n_err = 0;
    int n_pop = 0;
    logic [31:0] redir_q [$];
    logic [31:0] exp_pc = 32'h0;
    logic hold = 1'b0;
    logic [31:0] hold_pc = 32'h0;
    logic [31:0] hold_instr = 32'h0;

    if_fetch_if bus();

    if_fetch dut (
        .sclk(sclk),
        .rst(rst),
        .fetch_en(fetch_en),
        .redirect_vld(redirect_vld),
        .redirect_pc(redirect_pc),
        .bus(bus)
    );

    always #5 sclk = ~sclk;

    function automatic logic [31:0] iram(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // IRAM model: data for the strobed address appears the next cycle, junk otherwise.
    always @(posedge sclk) bus.rdata <= bus.mem_rd ? iram(bus.addr) : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor / scoreboard.
    always @(negedge sclk) begin
        if (rst) begin
            exp_pc = 32'h0;
            hold = 1'b0;
            chk("rst_if_valid", 32'(bus.if_valid), 32'd0);
            chk("rst_mem_rd", 32'(bus.mem_rd), 32'd0);
        end else begin
            if (hold) begin
                chk("hold_valid", 32'(bus.if_valid), 32'd1);
                chk("hold_pc", bus.if_pc, hold_pc);
                chk("hold_instr", bus.if_instr, hold_instr);
            end
            chk("mem_wr", 32'(bus.mem_wr), 32'd0);
            chk("addr_align", 32'(bus.addr[1:0]), 32'd0);
            if (bus.if_valid && bus.id_ready) begin
                chk("pop_pc", bus.if_pc, exp_pc);
                chk("pop_instr", bus.if_instr, iram(exp_pc));
                exp_pc += 32'd4;
                n_pop++;
            end
            if (redirect_vld) begin
                if (redir_q.size() == 0) begin
                    n_vec++;
                    n_err++;
                    $display("FAIL redir_q: got empty queue expected a target");
                end else begin
                    exp_pc = redir_q.pop_front();
                end
                chk("redir_mem_rd", 32'(bus.mem_rd), 32'(fetch_en));
                chk("redir_addr", bus.addr, exp_pc);
            end
            hold = bus.if_valid && !bus.id_ready && !redirect_vld;
            hold_pc = bus.if_pc;
            hold_instr = bus.if_instr;
        end
    end

    task automatic step();
        @(posedge sclk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset(input logic ready);
        rst = 1'b1;
        redirect_vld = 1'b0;
        fetch_en = 1'b1;
        bus.id_ready = ready;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic redirect(input logic [31:0] t);
        redirect_vld = 1'b1;
        redirect_pc = t;
        redir_q.push_back(t & ~32'h3);
    endtask

    task automatic wait_valid(input string name, input logic [31:0] pc);
        for (int i = 0; i < 20; i++) begin
            if (bus.if_valid) break;
            step();
        end
        chk({name, "_valid"}, 32'(bus.if_valid), 32'd1);
        chk({name, "_pc"}, bus.if_pc, pc);
    endtask

    initial begin
        bus.id_ready = 1'b1;
        fetch_en = 1'b1;
        step();
        settle();
        chk("rst_addr", bus.addr, 32'h0);
        chk("rst_pc", bus.if_pc, 32'h0);
        chk("rst_instr", bus.if_instr, NOP);

        // Streaming at one instruction per cycle.
        do_reset(1'b1);
        settle();
        chk("t1_rd0", 32'(bus.mem_rd), 32'd1);
        chk("t1_addr0", bus.addr, 32'h0);
        step();
        chk("t1_addr1", bus.addr, 32'h4);
        chk("t1_valid1", 32'(bus.if_valid), 32'd0);
        step();
        chk("t1_addr2", bus.addr, 32'h8);
        chk("t1_valid2", 32'(bus.if_valid), 32'd1);
        chk("t1_pc2", bus.if_pc, 32'h0);
        step();
        chk("t1_pc3", bus.if_pc, 32'h4);

        // Backpressure fills the buffer, then drains in order.
        do_reset(1'b0);
        step();
        step();
        chk("t2_rd_c2", 32'(bus.mem_rd), 32'd0);
        step();
        chk("t2_rd_c3", 32'(bus.mem_rd), 32'd0);
        chk("t2_addr_c3", bus.addr, 32'h8);
        chk("t2_head", bus.if_pc, 32'h0);
        bus.id_ready = 1'b1;
        step();
        chk("t2_pc4", bus.if_pc, 32'h4);
        step();
        chk("t2_pc8", bus.if_pc, 32'h8);

        // Redirect with 0x4 buffered and 0x8 in flight.
        do_reset(1'b1);
        step();
        step();
        step();
        bus.id_ready = 1'b0;
        chk("t3_head", bus.if_pc, 32'h4);
        redirect(32'h103);
        settle();
        chk("t3_rd", 32'(bus.mem_rd), 32'd1);
        chk("t3_addr", bus.addr, 32'h100);
        step();
        redirect_vld = 1'b0;
        bus.id_ready = 1'b1;
        wait_valid("t3_first", 32'h100);
        step();
        chk("t3_second", bus.if_pc, 32'h104);

        // Full buffer, pop and redirect together.
        do_reset(1'b0);
        step();
        step();
        step();
        bus.id_ready = 1'b1;
        redirect(32'h200);
        step();
        redirect_vld = 1'b0;
        wait_valid("t4_first", 32'h200);

        // fetch_en drops one cycle after an issue.
        do_reset(1'b1);
        step();
        fetch_en = 1'b0;
        settle();
        chk("t5_rd_off", 32'(bus.mem_rd), 32'd0);
        step();
        chk("t5_valid", 32'(bus.if_valid), 32'd1);
        chk("t5_pc", bus.if_pc, 32'h0);
        step();
        chk("t5_empty", 32'(bus.if_valid), 32'd0);
        chk("t5_rd_idle", 32'(bus.mem_rd), 32'd0);
        fetch_en = 1'b1;
        settle();
        chk("t5_resume_rd", 32'(bus.mem_rd), 32'd1);
        chk("t5_resume_addr", bus.addr, 32'h4);

        // Reset with buffered data and a read in flight.
        do_reset(1'b0);
        step();
        step();
        rst = 1'b1;
        step();
        chk("t6_valid", 32'(bus.if_valid), 32'd0);
        chk("t6_rd", 32'(bus.mem_rd), 32'd0);
        rst = 1'b0;
        bus.id_ready = 1'b1;
        settle();
        chk("t6_restart_rd", 32'(bus.mem_rd), 32'd1);
        chk("t6_restart_addr", bus.addr, 32'h0);
        step();
        wait_valid("t6_first", 32'h0);

        // Randomized traffic; the monitor scores every accepted instruction.
        n_pop = 0;
        for (int i = 0; i < 3000; i++) begin
            step();
            rst = ($urandom_range(0, 299) == 0);
            fetch_en = ($urandom_range(0, 7) != 0);
            bus.id_ready = ($urandom_range(0, 3) != 0);
            redirect_vld = 1'b0;
            if (!rst && $urandom_range(0, 15) == 0) redirect($urandom);
        end
        step();
        rst = 1'b0;
        redirect_vld = 1'b0;
        step();
        chk("random_progress", 32'(n_pop > 500), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end
endmodule
